// File: rtl/adc_spi_master.sv
// rtl/adc_spi_master.sv - 3-wire SPI initiator for ADC single-byte register access
//
// Purpose: serializes one 24-bit frame {rw, 2'b00, reg_addr, byte} MSB first
// on CSBn/SCLK/SDIO. On reads the last 8 bits are driven by the ADC and
// captured into rdata. The SDIO pad tristate is built outside from
// sdio_out/sdio_oe.
//
// Ports:
//   main_clk, rst            clock, synchronous active-high reset
//   start, rw, reg_addr,     transaction request; rw/reg_addr/wdata sampled
//   wdata                    when start is accepted (busy=0)
//   busy, done, rdata        status: in progress, end pulse, last read byte
//   ADC_CSBn, ADC_SCLK       SPI chip select (active low) and clock
//   sdio_out, sdio_oe,       SDIO drive value, drive enable, pad input
//   sdio_in
module adc_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 13
) (
    input  logic              main_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [7:0]        wdata,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rdata,
    output logic              ADC_CSBn,
    output logic              ADC_SCLK,
    output logic              sdio_out,
    output logic              sdio_oe,
    input  logic              sdio_in
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [23:0] tx;
    logic [7:0]  rx;
    logic        rw_q;
    logic [23:0] frame_in;

    assign frame_in = {rw, 2'b00, 13'(reg_addr), wdata};

    always_ff @(posedge main_clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx       <= '0;
            rx       <= '0;
            rw_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
            ADC_CSBn <= 1'b1;
            ADC_SCLK <= 1'b0;
            sdio_out <= 1'b0;
            sdio_oe  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SHIFT;
                        busy     <= 1'b1;
                        ADC_CSBn <= 1'b0;
                        ADC_SCLK <= 1'b0;
                        sdio_oe  <= 1'b1;
                        sdio_out <= rw;
                        tx       <= frame_in;
                        rw_q     <= rw;
                        div_cnt  <= '0;
                        bit_cnt  <= 5'd23;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!ADC_SCLK) begin
                            // Rising SCLK: sample the ADC during the data byte of a read.
                            ADC_SCLK <= 1'b1;
                            if (rw_q && bit_cnt < 5'd8)
                                rx <= {rx[6:0], sdio_in};
                        end else begin
                            ADC_SCLK <= 1'b0;
                            if (bit_cnt == 5'd0) begin
                                // sdio_out keeps bit0 (write) or 0 (read) through HOLD.
                                state <= HOLD;
                            end else begin
                                bit_cnt <= bit_cnt - 5'd1;
                                tx      <= {tx[22:0], 1'b0};
                                // Moving into bit7..0 of a read: release the line to the ADC.
                                if (rw_q && bit_cnt <= 5'd8) begin
                                    sdio_oe  <= 1'b0;
                                    sdio_out <= 1'b0;
                                end else begin
                                    sdio_out <= tx[22];
                                end
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        state    <= GAP;
                        div_cnt  <= '0;
                        ADC_CSBn <= 1'b1;
                        sdio_oe  <= 1'b0;
                        sdio_out <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (div_cnt == DIV_LAST) begin
                        state   <= IDLE;
                        div_cnt <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        if (rw_q)
                            rdata <= rx;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_master.sv
// tb/tb_adc_spi_master.sv - self-checking bench for adc_spi_master (CLK_DIV=4 and CLK_DIV=2)
module tb_adc_spi_master;

    logic        main_clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, rw = 1'b0, sdio_in = 1'b0;
    logic [12:0] reg_addr = '0;
    logic [7:0]  wdata = '0;
    logic        busy, done, csbn, sclk, sdio_out, sdio_oe;
    logic [7:0]  rdata;

    logic        start2 = 1'b0, rw2 = 1'b0, sdio_in2 = 1'b0;
    logic [12:0] reg_addr2 = '0;
    logic [7:0]  wdata2 = '0;
    logic        busy2, done2, csbn2, sclk2, sdio_out2, sdio_oe2;
    logic [7:0]  rdata2;

    int tests = 0;
    int fails = 0;

    always #5 main_clk = ~main_clk;

    adc_spi_master #(.CLK_DIV(4), .ADDR_W(13)) dut (
        .main_clk(main_clk), .rst(rst), .start(start), .rw(rw), .reg_addr(reg_addr),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .ADC_CSBn(csbn),
        .ADC_SCLK(sclk), .sdio_out(sdio_out), .sdio_oe(sdio_oe), .sdio_in(sdio_in)
    );

    adc_spi_master #(.CLK_DIV(2), .ADDR_W(13)) dut2 (
        .main_clk(main_clk), .rst(rst), .start(start2), .rw(rw2), .reg_addr(reg_addr2),
        .wdata(wdata2), .busy(busy2), .done(done2), .rdata(rdata2), .ADC_CSBn(csbn2),
        .ADC_SCLK(sclk2), .sdio_out(sdio_out2), .sdio_oe(sdio_oe2), .sdio_in(sdio_in2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rw;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  resp;
        bit          poke;
        logic [23:0] exp_frame;
        int          exp_oe;
        logic [7:0]  exp_rdata;
    } vec_t;

    // One frame on the CLK_DIV=4 instance. Cycle n is the state after edge T+n,
    // where T is the acceptance edge. Inputs are scrambled after acceptance; the
    // responder drives resp on SCLK falls of the data byte.
    task automatic run_txn(input logic r, input logic [12:0] a, input logic [7:0] d,
                           input logic [7:0] resp, input bit poke,
                           output logic [23:0] frame, output int rises, output int low_cyc,
                           output int oe_cyc, output int busy_cyc, output int done_cnt,
                           output int done_at);
        int  n;
        logic prev_sclk;
        frame = '0; rises = 0; low_cyc = 0; oe_cyc = 0; busy_cyc = 0; done_cnt = 0; done_at = 0;
        n = 0; prev_sclk = 1'b0;
        @(negedge main_clk);
        rw = r; reg_addr = a; wdata = d; start = 1'b1;
        @(posedge main_clk);
        while (n < 400 && !(done_cnt > 0 && n >= done_at + 3)) begin
            @(negedge main_clk);
            n++;
            if (n == 1) begin
                start = 1'b0; rw = ~r; reg_addr = ~a; wdata = ~d;
            end
            if (poke && n == 60) begin
                start = 1'b1; rw = 1'b1; reg_addr = 13'h0AAA;
            end
            if (poke && n == 61) start = 1'b0;
            if (!csbn) low_cyc++;
            if (!csbn && sdio_oe) oe_cyc++;
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                done_at = n;
            end
            if (sclk && !prev_sclk) begin
                rises++;
                frame = {frame[22:0], sdio_out};
            end
            if (!sclk && prev_sclk && rises >= 16 && rises < 24)
                sdio_in = resp[23 - rises];
            prev_sclk = sclk;
        end
    endtask

    vec_t vecs[4];
    logic [23:0] frame;
    int rises, low_cyc, oe_cyc, busy_cyc, done_cnt, done_at;

    initial begin
        // Frame = {rw, 00, addr[12:0], byte}; read data bits show as 0 on sdio_out.
        vecs[0] = '{1'b0, 13'h0014, 8'h41, 8'h00, 1'b0, 24'h001441, 196, 8'h00};
        vecs[1] = '{1'b1, 13'h0001, 8'h00, 8'hA5, 1'b0, 24'h800100, 128, 8'hA5};
        vecs[2] = '{1'b0, 13'h1ABC, 8'h3C, 8'h00, 1'b1, 24'h1ABC3C, 196, 8'hA5};
        vecs[3] = '{1'b1, 13'h00F0, 8'hC3, 8'h5A, 1'b0, 24'h80F000, 128, 8'h5A};

        repeat (3) @(negedge main_clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_csbn", csbn, 1);
        check("rst_sclk", sclk, 0);
        check("rst_sdio_out", sdio_out, 0);
        check("rst_sdio_oe", sdio_oe, 0);
        rst = 1'b0;
        repeat (2) @(negedge main_clk);

        for (int i = 0; i < 4; i++) begin
            run_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].resp, vecs[i].poke,
                    frame, rises, low_cyc, oe_cyc, busy_cyc, done_cnt, done_at);
            check($sformatf("v%0d_frame", i), frame, vecs[i].exp_frame);
            check($sformatf("v%0d_rises", i), rises, 24);
            check($sformatf("v%0d_csbn_low", i), low_cyc, 196);
            check($sformatf("v%0d_oe_cycles", i), oe_cyc, vecs[i].exp_oe);
            check($sformatf("v%0d_busy_cycles", i), busy_cyc, 200);
            check($sformatf("v%0d_done_count", i), done_cnt, 1);
            check($sformatf("v%0d_done_at", i), done_at, 201);
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end

        // Reset in the middle of the frame (after 12 SCLK rises).
        begin
            int n, r12, dn;
            logic ps;
            n = 0; r12 = 0; dn = 0; ps = 1'b0;
            @(negedge main_clk);
            rw = 1'b0; reg_addr = 13'h0055; wdata = 8'h77; start = 1'b1;
            @(posedge main_clk);
            while (n < 300 && r12 < 12) begin
                @(negedge main_clk);
                n++;
                start = 1'b0;
                if (sclk && !ps) r12++;
                ps = sclk;
            end
            check("midrst_reached_bit12", r12, 12);
            rst = 1'b1;
            @(negedge main_clk);
            check("midrst_csbn", csbn, 1);
            check("midrst_sclk", sclk, 0);
            check("midrst_oe", sdio_oe, 0);
            check("midrst_busy", busy, 0);
            check("midrst_done", done, 0);
            rst = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge main_clk);
                if (done) dn++;
            end
            check("midrst_no_done", dn, 0);
            run_txn(1'b0, 13'h0ACE, 8'h96, 8'h00, 1'b0,
                    frame, rises, low_cyc, oe_cyc, busy_cyc, done_cnt, done_at);
            check("postrst_frame", frame, 24'h0ACE96);
            check("postrst_done_at", done_at, 201);
        end

        // Back-to-back with start held: CSBn high = 4 GAP cycles + the done cycle.
        begin
            int gaps, hi_run, dones, n;
            int gap_len[2];
            int dones_at[2];
            bit seen_low;
            gaps = 0; hi_run = 0; dones = 0; n = 0; seen_low = 0;
            gap_len[0] = 0; gap_len[1] = 0; dones_at[0] = 0; dones_at[1] = 0;
            @(negedge main_clk);
            rw = 1'b0; reg_addr = 13'h0123; wdata = 8'h5A; start = 1'b1;
            while (n < 700 && gaps < 2) begin
                @(negedge main_clk);
                n++;
                if (done) dones++;
                if (!csbn) begin
                    if (seen_low && hi_run > 0) begin
                        gap_len[gaps] = hi_run;
                        dones_at[gaps] = dones;
                        gaps++;
                    end
                    seen_low = 1;
                    hi_run = 0;
                end else if (seen_low) begin
                    hi_run++;
                end
            end
            start = 1'b0;
            check("b2b_gaps", gaps, 2);
            check("b2b_gap0_len", gap_len[0], 5);
            check("b2b_gap1_len", gap_len[1], 5);
            check("b2b_dones0", dones_at[0], 1);
            check("b2b_dones1", dones_at[1], 2);
            rst = 1'b1;
            @(negedge main_clk);
            rst = 1'b0;
        end

        // CLK_DIV=2 instance: all-ones write, SCLK high phases 2 cycles each.
        begin
            int n, r2, lo, sl, hrun, bad, dat;
            logic ps;
            logic [23:0] f2;
            n = 0; r2 = 0; lo = 0; sl = 0; hrun = 0; bad = 0; dat = 0; ps = 1'b0; f2 = '0;
            @(negedge main_clk);
            rw2 = 1'b0; reg_addr2 = 13'h1FFF; wdata2 = 8'hFF; start2 = 1'b1;
            @(posedge main_clk);
            while (n < 200 && !(dat > 0 && n >= dat + 2)) begin
                @(negedge main_clk);
                n++;
                start2 = 1'b0;
                if (!csbn2) lo++;
                if (!csbn2 && !sclk2) sl++;
                if (sclk2) hrun++;
                else if (hrun > 0) begin
                    if (hrun != 2) bad++;
                    hrun = 0;
                end
                if (sclk2 && !ps) begin
                    r2++;
                    f2 = {f2[22:0], sdio_out2};
                end
                if (done2) dat = n;
                ps = sclk2;
            end
            check("div2_frame", f2, 24'h1FFFFF);
            check("div2_rises", r2, 24);
            check("div2_csbn_low", lo, 98);
            check("div2_sclk_low_cycles", sl, 50);
            check("div2_bad_high_phases", bad, 0);
            check("div2_done_at", dat, 101);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
